// File: rtl/vga_dec_pkg.sv
// Shared types and default timing for the VGA sync decoder.
// The default timing matches an 800x521 reference raster with 48/32 porches.
package vga_dec_pkg;

   typedef enum logic [1:0] {
      SEARCH  = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } dec_state_t;

   localparam int DEF_CNT_W        = 10;
   localparam int DEF_H_ACT_START  = 48;
   localparam int DEF_H_ACT        = 640;
   localparam int DEF_V_ACT_START  = 32;
   localparam int DEF_V_ACT        = 480;
   localparam int DEF_LOCK_FRAMES  = 2;
   localparam int REF_LINE_LEN     = 800;
   localparam int REF_FRAME_LINES  = 521;
   localparam int RGB_W            = 3;
   localparam int MATCH_W          = 8;

   // True when pos lies in the half-open window [start, start+len).
   function automatic logic in_window(input int pos, input int start, input int len);
      return (pos >= start) && (pos < start + len);
   endfunction

endpackage

// File: rtl/vga_dec_edge.sv
// Sync sampler: keeps the previous strobe's sync level and flags a rising
// edge (sync interval ending). Everything advances only on pixel strobes.
module vga_dec_edge (
   input  logic Clock,
   input  logic Reset,
   input  logic i_en,
   input  logic i_sync,
   output logic o_rise
);

   logic r_prev;

   // Previous sample idles high so a sync already high after reset is not an edge.
   always_ff @(posedge Clock) begin
      if (Reset)
         r_prev <= 1'b1;
      else if (i_en)
         r_prev <= i_sync;
   end

   assign o_rise = i_en & i_sync & ~r_prev;

endmodule

// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: rebuilds X/Y from the sync edges,
// measures line and frame periods and declares lock after LOCK_FRAMES
// identical frames. Optional statistics outputs (frame counter, lock-loss
// counter) are built when VGA_DEC_STATS_EN is defined.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   SEARCH  | no timing reference; waiting for a V_Sync rising edge
//   MEASURE | latching line length, counting identical frames
//   LOCKED  | periods stable; any mismatch or counter saturation drops out
module vga_sync_decoder
   import vga_dec_pkg::*;
#(
   parameter int CNT_W       = DEF_CNT_W,
   parameter int H_ACT_START = DEF_H_ACT_START,
   parameter int H_ACT       = DEF_H_ACT,
   parameter int V_ACT_START = DEF_V_ACT_START,
   parameter int V_ACT       = DEF_V_ACT,
   parameter int LOCK_FRAMES = DEF_LOCK_FRAMES
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic             iPixelEn,
   input  logic             iH_Sync,
   input  logic             iV_Sync,
   input  logic [RGB_W-1:0] iRGB,
   output logic [CNT_W-1:0] oCont_X,
   output logic [CNT_W-1:0] oCont_Y,
   output logic [RGB_W-1:0] oRGB,
   output logic             oActive,
   output logic             oLocked,
   output logic [CNT_W-1:0] oLineLen,
   output logic [CNT_W-1:0] oFrameLines
`ifdef VGA_DEC_STATS_EN
   ,
   output logic [15:0]      oFrameCnt,
   output logic [7:0]       oLockLoss
`endif
);

   localparam logic [CNT_W-1:0]   CNT_MAX  = '1;
   localparam logic [MATCH_W-1:0] LOCK_TGT = MATCH_W'(LOCK_FRAMES);

   dec_state_t         r_state;
   dec_state_t         w_state_nxt;
   logic [CNT_W-1:0]   r_x;
   logic [CNT_W-1:0]   r_y;
   logic [CNT_W-1:0]   w_x_nxt;
   logic [CNT_W-1:0]   w_y_nxt;
   logic [CNT_W-1:0]   r_line_ref;
   logic [CNT_W-1:0]   w_line_ref_nxt;
   logic               r_line_ref_vld;
   logic               w_line_ref_vld_nxt;
   logic [CNT_W-1:0]   r_frame_ref;
   logic [CNT_W-1:0]   w_frame_ref_nxt;
   logic [MATCH_W-1:0] r_match;
   logic [MATCH_W-1:0] w_match_nxt;
   logic [MATCH_W-1:0] w_match_inc;
   logic               r_locked;
   logic               r_active;
   logic [RGB_W-1:0]   r_rgb;
   logic               w_locked_nxt;
   logic               w_active_nxt;
   logic               w_h_rise;
   logic               w_v_rise;
   logic [CNT_W-1:0]   w_line_meas;
   logic [CNT_W-1:0]   w_frame_meas;
   logic               w_line_bad;
   logic               w_frame_bad;
   logic               w_cnt_sat;

   vga_dec_edge u_h_edge (
      .Clock  (Clock),
      .Reset  (Reset),
      .i_en   (iPixelEn),
      .i_sync (iH_Sync),
      .o_rise (w_h_rise)
   );

   vga_dec_edge u_v_edge (
      .Clock  (Clock),
      .Reset  (Reset),
      .i_en   (iPixelEn),
      .i_sync (iV_Sync),
      .o_rise (w_v_rise)
   );

   // Periods are the count reached on the strobe before the edge, plus one.
   assign w_line_meas  = r_x + CNT_W'(1);
   assign w_frame_meas = r_y + CNT_W'(1);
   assign w_line_bad   = w_h_rise && (w_line_meas != r_line_ref);
   assign w_frame_bad  = w_v_rise && (w_frame_meas != r_frame_ref);

   // Saturating position counters; V edge has priority over H edge for Y.
   always_comb begin
      w_x_nxt = r_x;
      w_y_nxt = r_y;
      if (w_h_rise)
         w_x_nxt = '0;
      else if (r_x != CNT_MAX)
         w_x_nxt = r_x + CNT_W'(1);
      if (w_v_rise)
         w_y_nxt = '0;
      else if (w_h_rise && (r_y != CNT_MAX))
         w_y_nxt = r_y + CNT_W'(1);
   end

   // A counter pinned at its ceiling means a sync edge went missing.
   assign w_cnt_sat = (w_x_nxt == CNT_MAX) || (w_y_nxt == CNT_MAX);

   // Next-state and reference bookkeeping.
   always_comb begin
      w_state_nxt        = r_state;
      w_line_ref_nxt     = r_line_ref;
      w_line_ref_vld_nxt = r_line_ref_vld;
      w_frame_ref_nxt    = r_frame_ref;
      w_match_nxt        = r_match;
      w_match_inc        = r_match + MATCH_W'(1);
      case (r_state)
         SEARCH: begin
            if (w_v_rise) begin
               w_state_nxt        = MEASURE;
               w_match_nxt        = '0;
               w_line_ref_vld_nxt = 1'b0;
            end
         end
         MEASURE: begin
            if (w_h_rise && !r_line_ref_vld) begin
               w_line_ref_nxt     = w_line_meas;
               w_line_ref_vld_nxt = 1'b1;
            end
            if (w_h_rise && r_line_ref_vld && w_line_bad) begin
               w_state_nxt = SEARCH;
            end else if (w_v_rise) begin
               // A differing frame restarts the count with itself as the reference.
               if (w_frame_bad) begin
                  w_frame_ref_nxt = w_frame_meas;
                  w_match_inc     = MATCH_W'(1);
               end
               w_match_nxt = w_match_inc;
               if (w_match_inc >= LOCK_TGT)
                  w_state_nxt = LOCKED;
            end
         end
         LOCKED: begin
            if (w_line_bad || w_frame_bad || w_cnt_sat)
               w_state_nxt = SEARCH;
         end
         default: w_state_nxt = SEARCH;
      endcase
   end

   // Outputs describe the same strobe the counters are moving to.
   always_comb begin
      w_locked_nxt = (w_state_nxt == LOCKED);
      w_active_nxt = w_locked_nxt
                     && in_window(int'(w_x_nxt), H_ACT_START, H_ACT)
                     && in_window(int'(w_y_nxt), V_ACT_START, V_ACT);
   end

   // State, counters and registered outputs; everything holds between strobes.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state        <= SEARCH;
         r_x            <= '0;
         r_y            <= '0;
         r_line_ref     <= '0;
         r_line_ref_vld <= 1'b0;
         r_frame_ref    <= '0;
         r_match        <= '0;
         r_locked       <= 1'b0;
         r_active       <= 1'b0;
         r_rgb          <= '0;
      end else if (iPixelEn) begin
         r_state        <= w_state_nxt;
         r_x            <= w_x_nxt;
         r_y            <= w_y_nxt;
         r_line_ref     <= w_line_ref_nxt;
         r_line_ref_vld <= w_line_ref_vld_nxt;
         r_frame_ref    <= w_frame_ref_nxt;
         r_match        <= w_match_nxt;
         r_locked       <= w_locked_nxt;
         r_active       <= w_active_nxt;
         r_rgb          <= w_active_nxt ? iRGB : '0;
      end
   end

   assign oCont_X     = r_x;
   assign oCont_Y     = r_y;
   assign oRGB        = r_rgb;
   assign oActive     = r_active;
   assign oLocked     = r_locked;
   assign oLineLen    = r_line_ref;
   assign oFrameLines = r_frame_ref;

`ifdef VGA_DEC_STATS_EN
   logic [15:0] r_frame_cnt;
   logic [7:0]  r_lock_loss;

   // Locked frames counted at each V edge that keeps lock; lock losses saturate.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_frame_cnt <= '0;
         r_lock_loss <= '0;
      end else if (iPixelEn && (r_state == LOCKED)) begin
         if (w_state_nxt != LOCKED) begin
            if (r_lock_loss != 8'hFF)
               r_lock_loss <= r_lock_loss + 8'd1;
         end else if (w_v_rise) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign oFrameCnt = r_frame_cnt;
   assign oLockLoss = r_lock_loss;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a reduced raster (40 strobes x 12 lines)
// so that many frames fit in a short run. A behavioural model feeds a
// scoreboard every clock; fixed expectations cover lock, window and faults.
module tb_vga_sync_decoder;

   localparam int CW    = 6;
   localparam int MAXV  = 63;
   localparam int LINE  = 40;
   localparam int HSW   = 6;
   localparam int FRAME = 12;
   localparam int VSW   = 2;
   localparam int HAS   = 4;
   localparam int HA    = 24;
   localparam int VAS   = 2;
   localparam int VA    = 8;
   localparam int LF    = 2;

   logic          Clock = 1'b0;
   logic          Reset = 1'b1;
   logic          iPixelEn = 1'b0;
   logic          iH_Sync = 1'b1;
   logic          iV_Sync = 1'b1;
   logic [2:0]    iRGB = 3'b000;
   logic [CW-1:0] oCont_X, oCont_Y, oLineLen, oFrameLines;
   logic [2:0]    oRGB;
   logic          oActive, oLocked;
`ifdef VGA_DEC_STATS_EN
   logic [15:0]   oFrameCnt;
   logic [7:0]    oLockLoss;
`endif

   vga_sync_decoder #(
      .CNT_W(CW), .H_ACT_START(HAS), .H_ACT(HA),
      .V_ACT_START(VAS), .V_ACT(VA), .LOCK_FRAMES(LF)
   ) dut (
      .Clock(Clock), .Reset(Reset), .iPixelEn(iPixelEn),
      .iH_Sync(iH_Sync), .iV_Sync(iV_Sync), .iRGB(iRGB),
      .oCont_X(oCont_X), .oCont_Y(oCont_Y), .oRGB(oRGB),
      .oActive(oActive), .oLocked(oLocked),
      .oLineLen(oLineLen), .oFrameLines(oFrameLines)
`ifdef VGA_DEC_STATS_EN
      , .oFrameCnt(oFrameCnt), .oLockLoss(oLockLoss)
`endif
   );

   always #5 Clock = ~Clock;

   typedef struct {
      int x, y, rgb, act, lck, ll, fl, fcnt, lloss;
   } exp_t;

   typedef struct {
      int x, y;
      logic [2:0] rgb;
      int act;
      int orgb;
   } win_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   // source raster position and current line length
   int sx = 0, sy = 0, cur_len = LINE;
   bit toggle = 0;

   // behavioural reference
   int m_x = 0, m_y = 0, m_ph = 1, m_pv = 1, m_st = 0, m_match = 0;
   int m_lref = 0, m_lvld = 0, m_fref = 0, m_lck = 0, m_act = 0, m_rgb = 0;
   int m_fcnt = 0, m_lloss = 0;

   task automatic model_clock();
      int hr, vr, nx, ny, lm, fm;
      bit bad;
      exp_t e;
      if (Reset) begin
         m_x = 0; m_y = 0; m_ph = 1; m_pv = 1; m_st = 0; m_match = 0;
         m_lref = 0; m_lvld = 0; m_fref = 0; m_lck = 0; m_act = 0; m_rgb = 0;
         m_fcnt = 0; m_lloss = 0;
      end else if (iPixelEn) begin
         hr = (iH_Sync && m_ph == 0) ? 1 : 0;
         vr = (iV_Sync && m_pv == 0) ? 1 : 0;
         m_ph = int'(iH_Sync);
         m_pv = int'(iV_Sync);
         nx = hr ? 0 : ((m_x == MAXV) ? MAXV : m_x + 1);
         ny = vr ? 0 : (hr ? ((m_y == MAXV) ? MAXV : m_y + 1) : m_y);
         lm = (m_x + 1) % (MAXV + 1);
         fm = (m_y + 1) % (MAXV + 1);
         case (m_st)
            0: if (vr) begin m_st = 1; m_match = 0; m_lvld = 0; end
            1: begin
               bad = 0;
               if (hr) begin
                  if (m_lvld == 0) begin m_lref = lm; m_lvld = 1; end
                  else if (lm != m_lref) bad = 1;
               end
               if (bad) m_st = 0;
               else if (vr) begin
                  if (fm == m_fref) m_match++;
                  else begin m_fref = fm; m_match = 1; end
                  if (m_match >= LF) m_st = 2;
               end
            end
            default: begin
               if ((hr && lm != m_lref) || (vr && fm != m_fref) || nx == MAXV || ny == MAXV) begin
                  m_st = 0;
                  if (m_lloss < 255) m_lloss++;
               end else if (vr) m_fcnt = (m_fcnt + 1) % 65536;
            end
         endcase
         m_x = nx; m_y = ny;
         m_lck = (m_st == 2) ? 1 : 0;
         m_act = (m_lck && nx >= HAS && nx < HAS + HA && ny >= VAS && ny < VAS + VA) ? 1 : 0;
         m_rgb = m_act ? int'(iRGB) : 0;
      end
      e.x = m_x; e.y = m_y; e.rgb = m_rgb; e.act = m_act; e.lck = m_lck;
      e.ll = m_lck ? m_lref : m_lref; e.fl = m_fref; e.fcnt = m_fcnt; e.lloss = m_lloss;
      sb_q.push_back(e);
   endtask

   task automatic check_sb();
      exp_t e;
      int fc, ls;
      if (sb_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL sb_empty at %0t", $time);
         return;
      end
      e = sb_q.pop_front();
      fc = e.fcnt; ls = e.lloss;
`ifdef VGA_DEC_STATS_EN
      fc = int'(oFrameCnt); ls = int'(oLockLoss);
`endif
      checks++;
      if (int'(oCont_X) != e.x || int'(oCont_Y) != e.y || int'(oRGB) != e.rgb ||
          int'(oActive) != e.act || int'(oLocked) != e.lck || int'(oLineLen) != e.ll ||
          int'(oFrameLines) != e.fl || fc != e.fcnt || ls != e.lloss) begin
         errors++;
         $display("FAIL sb t=%0t got x=%0d y=%0d rgb=%0d act=%0d lck=%0d ll=%0d fl=%0d fc=%0d ls=%0d want x=%0d y=%0d rgb=%0d act=%0d lck=%0d ll=%0d fl=%0d fc=%0d ls=%0d",
                  $time, oCont_X, oCont_Y, oRGB, oActive, oLocked, oLineLen, oFrameLines, fc, ls,
                  e.x, e.y, e.rgb, e.act, e.lck, e.ll, e.fl, e.fcnt, e.lloss);
      end
   endtask

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   // One source strobe (plus one idle clock in toggle mode), then advance the raster.
   task automatic strobe(input logic [2:0] rgb, input bit hforce, input bit rst);
      @(negedge Clock);
      iH_Sync  = hforce ? 1'b1 : (sx < cur_len - HSW);
      iV_Sync  = (sy < FRAME - VSW);
      iRGB     = rgb;
      iPixelEn = 1'b1;
      Reset    = rst;
      @(posedge Clock);
      model_clock();
      #1 check_sb();
      sx++;
      if (sx >= cur_len) begin
         sx = 0; cur_len = LINE; sy++;
         if (sy >= FRAME) sy = 0;
      end
      if (toggle) begin
         @(negedge Clock);
         iPixelEn = 1'b0;
         Reset    = 1'b0;
         iH_Sync  = 1'($urandom);
         iV_Sync  = 1'($urandom);
         iRGB     = 3'($urandom);
         @(posedge Clock);
         model_clock();
         #1 check_sb();
      end
   endtask

   task automatic run_to(input int x, input int y);
      int n = 0;
      while (!(sx == x && sy == y) && n < 2 * LINE * FRAME) begin
         strobe(3'($urandom_range(0, 7)), 1'b0, 1'b0);
         n++;
      end
      if (!(sx == x && sy == y)) begin
         checks++; errors++;
         $display("FAIL run_to actual=%0d,%0d required=%0d,%0d", sx, sy, x, y);
      end
   endtask

   task automatic relock(input string tag);
      run_to(0, 0); strobe(3'd1, 1'b0, 1'b0);
      chk({tag, "_meas_unlocked"}, int'(oLocked), 0);
      run_to(0, 0); strobe(3'd1, 1'b0, 1'b0);
      chk({tag, "_match1_unlocked"}, int'(oLocked), 0);
      run_to(0, 0); strobe(3'd1, 1'b0, 1'b0);
      chk({tag, "_locked"}, int'(oLocked), 1);
   endtask

   win_t wt[7];

   initial begin
      wt[0] = '{x:10, y:1,  rgb:3'b111, act:0, orgb:0};
      wt[1] = '{x:3,  y:2,  rgb:3'b101, act:0, orgb:0};
      wt[2] = '{x:4,  y:2,  rgb:3'b101, act:1, orgb:5};
      wt[3] = '{x:28, y:2,  rgb:3'b101, act:0, orgb:0};
      wt[4] = '{x:15, y:5,  rgb:3'b110, act:1, orgb:6};
      wt[5] = '{x:27, y:9,  rgb:3'b011, act:1, orgb:3};
      wt[6] = '{x:27, y:10, rgb:3'b011, act:0, orgb:0};

      for (int pass = 0; pass < 2; pass++) begin
         toggle = (pass == 1);
         sx = 0; sy = 0; cur_len = LINE;
         strobe(3'd7, 1'b0, 1'b1);
         chk("rst_x", int'(oCont_X), 0);
         chk("rst_locked", int'(oLocked), 0);
         chk("rst_linelen", int'(oLineLen), 0);

         // lock acquisition
         relock("acq");
         chk("acq_linelen", int'(oLineLen), LINE);
         chk("acq_framelines", int'(oFrameLines), FRAME);
         chk("acq_xy", int'(oCont_X) + int'(oCont_Y), 0);

         // active window corners
         for (int i = 0; i < 7; i++) begin
            run_to(wt[i].x, wt[i].y);
            strobe(wt[i].rgb, 1'b0, 1'b0);
            chk("win_active", int'(oActive), wt[i].act);
            chk("win_rgb", int'(oRGB), wt[i].orgb);
            chk("win_x", int'(oCont_X), wt[i].x);
            chk("win_y", int'(oCont_Y), wt[i].y);
         end

         // one short line
         run_to(0, 4);
         cur_len = LINE - 1;
         run_to(LINE - 2, 4); strobe(3'd2, 1'b0, 1'b0);
         chk("short_before_locked", int'(oLocked), 1);
         strobe(3'd2, 1'b0, 1'b0);
         chk("short_drop_locked", int'(oLocked), 0);
         chk("short_drop_x", int'(oCont_X), 0);
         relock("short");
`ifdef VGA_DEC_STATS_EN
         chk("stats_lockloss", int'(oLockLoss), 1);
         chk("stats_framecnt_nz", int'(oFrameCnt != 16'd0), 1);
`endif

         // H sync stuck high: X saturates, lock drops, no wrap
         run_to(10, 3);
         for (int i = 0; i < 53; i++) strobe(3'd4, 1'b1, 1'b0);
         chk("sat_x62", int'(oCont_X), 62);
         chk("sat_still_locked", int'(oLocked), 1);
         strobe(3'd4, 1'b1, 1'b0);
         chk("sat_x63", int'(oCont_X), MAXV);
         chk("sat_unlocked", int'(oLocked), 0);
         for (int i = 0; i < 6; i++) strobe(3'd4, 1'b1, 1'b0);
         chk("sat_nowrap", int'(oCont_X), MAXV);
         relock("sat");

         // reset in the middle of a locked frame
         run_to(0, 5);
         strobe(3'd7, 1'b0, 1'b1);
         chk("midrst_x", int'(oCont_X), 0);
         chk("midrst_y", int'(oCont_Y), 0);
         chk("midrst_locked", int'(oLocked), 0);
         chk("midrst_active", int'(oActive), 0);
         chk("midrst_rgb", int'(oRGB), 0);
         chk("midrst_ll", int'(oLineLen), 0);
         chk("midrst_fl", int'(oFrameLines), 0);
         relock("midrst");
         chk("midrst_relock_ll", int'(oLineLen), LINE);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog checks=%0d errors=%0d", checks, errors + 1);
      $fatal(1, "watchdog expired");
   end

endmodule
